// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode/func constants and control encodings for the MIPS32 main decoder
package mips_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_SPECIAL3 = 6'h1F;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;
  localparam logic [5:0] F_CLZ   = 6'h20;
  localparam logic [5:0] F_CLO   = 6'h21;
  localparam logic [5:0] F_BSHFL = 6'h20;

  localparam logic [4:0] SA_SEB  = 5'h10;
  localparam logic [4:0] SA_SEH  = 5'h18;
  localparam logic [3:0] WEN_ALL = 4'hF;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_ADDU = 4'h1, ALU_SUB = 4'h2, ALU_SUBU = 4'h3,
    ALU_AND = 4'h4, ALU_OR = 4'h5, ALU_XOR = 4'h6, ALU_NOR = 4'h7,
    ALU_SLT = 4'h8, ALU_SLTU = 4'h9, ALU_CLZ = 4'hA, ALU_CLO = 4'hB,
    ALU_SEB = 4'hC, ALU_SEH = 4'hD, ALU_RSVD = 4'hE, ALU_PASS_B = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {SH_SLL = 2'b00, SH_SRL = 2'b01, SH_SRA = 2'b10, SH_ROTR = 2'b11} shift_op_e;

  typedef enum logic [2:0] {
    COND_NONE = 3'd0, COND_BEQ = 3'd1, COND_BNE = 3'd2, COND_BLTZ = 3'd3,
    COND_BGEZ = 3'd4, COND_BLEZ = 3'd5, COND_BGTZ = 3'd6, COND_RSVD = 3'd7
  } cond_e;

  typedef enum logic [1:0] {B_REG = 2'b00, B_IMM_EXT = 2'b01, B_IMM_HI = 2'b10, B_ZERO = 2'b11} b_sel_e;

  typedef struct packed {
    logic [3:0] wen;
    b_sel_e     b_in_sel;
    logic       extend_sel;
    alu_op_e    alu_op;
    logic       rd_addr_sel;
    logic       shift_amount_sel;
    logic       alu_shift_sel;
    cond_e      condition;
    shift_op_e  shift_op;
    logic       jump;
    logic       rt_addr_sel;
  } ctrl_t;

endpackage

// File: rtl/mips_controller_if.sv
// rtl/mips_controller_if.sv - instruction fields in, control selects out; Illegal_op only with CTRL_ILLEGAL_OP_EN
interface mips_controller_if;
  logic [5:0] op;
  logic [4:0] Rs;
  logic [4:0] Rt;
  logic [4:0] Shamt;
  logic [5:0] Func;
  logic       Overflow_out;
  logic [3:0] Rd_byte_w_en;
  logic [1:0] B_in_sel;
  logic       Extend_sel;
  logic [3:0] ALU_op;
  logic       Rd_addr_sel;
  logic       Shift_amount_sel;
  logic       ALU_Shift_sel;
  logic [2:0] condition;
  logic [1:0] Shift_op;
  logic       Jump;
  logic       Rt_addr_sel;
  logic       Ovf_sticky;
`ifdef CTRL_ILLEGAL_OP_EN
  logic       Illegal_op;
`endif

  modport master (
    output op, Rs, Rt, Shamt, Func, Overflow_out,
    input  Rd_byte_w_en, B_in_sel, Extend_sel, ALU_op, Rd_addr_sel, Shift_amount_sel,
           ALU_Shift_sel, condition, Shift_op, Jump, Rt_addr_sel, Ovf_sticky
`ifdef CTRL_ILLEGAL_OP_EN
    , input Illegal_op
`endif
  );

  modport slave (
    input  op, Rs, Rt, Shamt, Func, Overflow_out,
    output Rd_byte_w_en, B_in_sel, Extend_sel, ALU_op, Rd_addr_sel, Shift_amount_sel,
           ALU_Shift_sel, condition, Shift_op, Jump, Rt_addr_sel, Ovf_sticky
`ifdef CTRL_ILLEGAL_OP_EN
    , output Illegal_op
`endif
  );
endinterface

// File: rtl/mips_func_decoder.sv
// rtl/mips_func_decoder.sv - SPECIAL (op=0) Func/Rs/Shamt decode to ALU/shifter controls
module mips_func_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] func,
  input  logic [4:0] rs,
  input  logic [4:0] shamt,
  output alu_op_e    alu_op,
  output shift_op_e  shift_op,
  output logic       alu_shift_sel,
  output logic       shift_amount_sel,
  output logic       trap,
  output logic       valid
);

  always_comb begin
    alu_op           = ALU_ADD;
    shift_op         = SH_SLL;
    alu_shift_sel    = 1'b0;
    shift_amount_sel = 1'b0;
    trap             = 1'b0;
    valid            = 1'b0;
    case (func)
      F_SLL:  begin valid = 1'b1; alu_shift_sel = 1'b1; shift_op = SH_SLL; end
      // Rs (resp. Shamt for the variable form) selects plain logical shift vs rotate
      F_SRL:  begin
        valid         = (rs == 5'd0) || (rs == 5'd1);
        alu_shift_sel = valid;
        shift_op      = (rs == 5'd1) ? SH_ROTR : (valid ? SH_SRL : SH_SLL);
      end
      F_SRA:  begin valid = 1'b1; alu_shift_sel = 1'b1; shift_op = SH_SRA; end
      F_SLLV: begin valid = 1'b1; alu_shift_sel = 1'b1; shift_amount_sel = 1'b1; shift_op = SH_SLL; end
      F_SRLV: begin
        valid            = (shamt == 5'd0) || (shamt == 5'd1);
        alu_shift_sel    = valid;
        shift_amount_sel = valid;
        shift_op         = (shamt == 5'd1) ? SH_ROTR : (valid ? SH_SRL : SH_SLL);
      end
      F_SRAV: begin valid = 1'b1; alu_shift_sel = 1'b1; shift_amount_sel = 1'b1; shift_op = SH_SRA; end
      F_ADD:  begin valid = 1'b1; alu_op = ALU_ADD; trap = 1'b1; end
      F_ADDU: begin valid = 1'b1; alu_op = ALU_ADDU; end
      F_SUB:  begin valid = 1'b1; alu_op = ALU_SUB; trap = 1'b1; end
      F_SUBU: begin valid = 1'b1; alu_op = ALU_SUBU; end
      F_AND:  begin valid = 1'b1; alu_op = ALU_AND; end
      F_OR:   begin valid = 1'b1; alu_op = ALU_OR; end
      F_XOR:  begin valid = 1'b1; alu_op = ALU_XOR; end
      F_NOR:  begin valid = 1'b1; alu_op = ALU_NOR; end
      F_SLT:  begin valid = 1'b1; alu_op = ALU_SLT; end
      F_SLTU: begin valid = 1'b1; alu_op = ALU_SLTU; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// rtl/mips_controller.sv - single-cycle MIPS32 main decoder; CTRL_ILLEGAL_OP_EN adds Illegal_op
module mips_controller
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mips_controller_if.slave   bus
);

  alu_op_e   fd_alu_op;
  shift_op_e fd_shift_op;
  logic      fd_alu_shift_sel, fd_shift_amount_sel, fd_trap, fd_valid;
  ctrl_t     dec, ctrl;
  logic      legal, trap, suppress;
  logic      ovf_sticky_q, ovf_sticky_d;

  mips_func_decoder u_func_dec (
    .func             (bus.Func),
    .rs               (bus.Rs),
    .shamt            (bus.Shamt),
    .alu_op           (fd_alu_op),
    .shift_op         (fd_shift_op),
    .alu_shift_sel    (fd_alu_shift_sel),
    .shift_amount_sel (fd_shift_amount_sel),
    .trap             (fd_trap),
    .valid            (fd_valid)
  );

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    trap  = 1'b0;
    case (bus.op)
      OP_SPECIAL: begin
        legal                = fd_valid;
        trap                 = fd_trap;
        dec.wen              = WEN_ALL;
        dec.alu_op           = fd_alu_op;
        dec.shift_op         = fd_shift_op;
        dec.alu_shift_sel    = fd_alu_shift_sel;
        dec.shift_amount_sel = fd_shift_amount_sel;
      end
      OP_REGIMM: begin
        legal           = (bus.Rt == 5'd0) || (bus.Rt == 5'd1);
        dec.condition   = (bus.Rt == 5'd0) ? COND_BLTZ : COND_BGEZ;
        dec.rt_addr_sel = 1'b1;
        dec.b_in_sel    = B_ZERO;
        dec.alu_op      = ALU_SUB;
      end
      OP_BEQ, OP_BNE: begin
        legal         = 1'b1;
        dec.condition = (bus.op == OP_BEQ) ? COND_BEQ : COND_BNE;
        dec.alu_op    = ALU_SUB;
      end
      OP_BLEZ, OP_BGTZ: begin
        legal           = (bus.Rt == 5'd0);
        dec.condition   = (bus.op == OP_BLEZ) ? COND_BLEZ : COND_BGTZ;
        dec.rt_addr_sel = 1'b1;
        dec.b_in_sel    = B_ZERO;
        dec.alu_op      = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        legal           = 1'b1;
        trap            = (bus.op == OP_ADDI);
        dec.wen         = WEN_ALL;
        dec.rd_addr_sel = 1'b1;
        dec.b_in_sel    = B_IMM_EXT;
        dec.extend_sel  = (bus.op <= OP_SLTIU);
        case (bus.op)
          OP_ADDI:  dec.alu_op = ALU_ADD;
          OP_ADDIU: dec.alu_op = ALU_ADDU;
          OP_SLTI:  dec.alu_op = ALU_SLT;
          OP_SLTIU: dec.alu_op = ALU_SLTU;
          OP_ANDI:  dec.alu_op = ALU_AND;
          OP_ORI:   dec.alu_op = ALU_OR;
          default:  dec.alu_op = ALU_XOR;
        endcase
      end
      OP_LUI: begin
        legal           = 1'b1;
        dec.wen         = WEN_ALL;
        dec.rd_addr_sel = 1'b1;
        dec.b_in_sel    = B_IMM_HI;
        dec.alu_op      = ALU_PASS_B;
      end
      OP_SPECIAL2: begin
        legal      = (bus.Func == F_CLZ) || (bus.Func == F_CLO);
        dec.wen    = WEN_ALL;
        dec.alu_op = (bus.Func == F_CLO) ? ALU_CLO : ALU_CLZ;
      end
      OP_SPECIAL3: begin
        legal      = (bus.Func == F_BSHFL) && ((bus.Shamt == SA_SEB) || (bus.Shamt == SA_SEH));
        dec.wen    = WEN_ALL;
        dec.alu_op = (bus.Shamt == SA_SEH) ? ALU_SEH : ALU_SEB;
      end
      OP_J: begin
        legal    = 1'b1;
        dec.jump = 1'b1;
      end
      default: ;
    endcase
  end

  // Illegal encodings collapse to all-zero; overflow and reset gate only the side-effecting fields
  always_comb begin
    suppress = legal & trap & bus.Overflow_out;
    ctrl     = legal ? dec : '0;
    if (suppress || !rst_n) ctrl.wen = 4'h0;
    if (!rst_n) begin
      ctrl.jump      = 1'b0;
      ctrl.condition = COND_NONE;
    end
  end

  always_comb begin
    ovf_sticky_d = ovf_sticky_q | suppress;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_sticky_q <= 1'b0;
    else        ovf_sticky_q <= ovf_sticky_d;
  end

  assign bus.Rd_byte_w_en     = ctrl.wen;
  assign bus.B_in_sel         = ctrl.b_in_sel;
  assign bus.Extend_sel       = ctrl.extend_sel;
  assign bus.ALU_op           = ctrl.alu_op;
  assign bus.Rd_addr_sel      = ctrl.rd_addr_sel;
  assign bus.Shift_amount_sel = ctrl.shift_amount_sel;
  assign bus.ALU_Shift_sel    = ctrl.alu_shift_sel;
  assign bus.condition        = ctrl.condition;
  assign bus.Shift_op         = ctrl.shift_op;
  assign bus.Jump             = ctrl.jump;
  assign bus.Rt_addr_sel      = ctrl.rt_addr_sel;
  assign bus.Ovf_sticky       = ovf_sticky_q;
`ifdef CTRL_ILLEGAL_OP_EN
  assign bus.Illegal_op       = rst_n & ~legal;
`endif

endmodule

// File: tb/tb_mips_controller.sv
// tb/tb_mips_controller.sv - directed scoreboard bench for mips_controller
module tb_mips_controller;

  typedef struct packed {
    logic [3:0] wen;
    logic [1:0] bsel;
    logic       ext;
    logic [3:0] alu;
    logic       rdsel;
    logic       shsel;
    logic       alush;
    logic [2:0] cond;
    logic [1:0] shop;
    logic       jump;
    logic       rtsel;
    logic       sticky;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } sb_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  sb_t  sb_q[$];
  logic sticky_m = 1'b0;
  logic prev_rst = 1'b0;
  logic prev_supp = 1'b0;

  mips_controller_if bus();

  mips_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] wen, input logic [1:0] bsel, input logic ext,
                              input logic [3:0] alu, input logic rdsel, input logic shsel,
                              input logic alush, input logic [2:0] cond, input logic [1:0] shop,
                              input logic jump, input logic rtsel);
    return {wen, bsel, ext, alu, rdsel, shsel, alush, cond, shop, jump, rtsel, 1'b0};
  endfunction

  task automatic step(input string tag, input logic rst, input logic [5:0] op_i,
                      input logic [4:0] rs_i, input logic [4:0] rt_i, input logic [4:0] sh_i,
                      input logic [5:0] fn_i, input logic ovf_i, input obs_t e);
    sb_t  item;
    obs_t got;
    @(posedge clk);
    if (!prev_rst) sticky_m = 1'b0;
    else if (prev_supp) sticky_m = 1'b1;
    #1;
    rst_n            = rst;
    bus.op           = op_i;
    bus.Rs           = rs_i;
    bus.Rt           = rt_i;
    bus.Shamt        = sh_i;
    bus.Func         = fn_i;
    bus.Overflow_out = ovf_i;
    e.sticky  = sticky_m;
    item.tag  = tag;
    item.exp  = e;
    sb_q.push_back(item);
    prev_rst  = rst;
    prev_supp = rst && ovf_i && (((op_i == 6'h00) && ((fn_i == 6'h20) || (fn_i == 6'h22))) || (op_i == 6'h08));
    #2;
    got = {bus.Rd_byte_w_en, bus.B_in_sel, bus.Extend_sel, bus.ALU_op, bus.Rd_addr_sel,
           bus.Shift_amount_sel, bus.ALU_Shift_sel, bus.condition, bus.Shift_op, bus.Jump,
           bus.Rt_addr_sel, bus.Ovf_sticky};
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      item = sb_q.pop_front();
      total++;
      assert (got === item.exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", item.tag, got, item.exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.op = '0; bus.Rs = '0; bus.Rt = '0; bus.Shamt = '0; bus.Func = '0; bus.Overflow_out = 1'b0;

    //    tag          rst op     rs    rt    sh     fn     ovf   wen   bs   ex   alu   rd   ss   as   cond  shop  j    rt
    step("rst_add",   0, 6'h00, 5'd0, 5'd0, 5'd0,  6'h20, 1'b0, mk(4'h0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("rst_addi",  0, 6'h08, 5'd0, 5'd0, 5'd0,  6'h00, 1'b0, mk(4'h0,2'd1,1'b1,4'h0,1'b1,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("add",       1, 6'h00, 5'd3, 5'd4, 5'd0,  6'h20, 1'b0, mk(4'hF,2'd0,1'b0,4'h0,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("add_ovf",   1, 6'h00, 5'd3, 5'd4, 5'd0,  6'h20, 1'b1, mk(4'h0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("addu_ovf",  1, 6'h00, 5'd3, 5'd4, 5'd0,  6'h21, 1'b1, mk(4'hF,2'd0,1'b0,4'h1,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("sub_ovf",   1, 6'h00, 5'd1, 5'd2, 5'd0,  6'h22, 1'b1, mk(4'h0,2'd0,1'b0,4'h2,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("subu",      1, 6'h00, 5'd1, 5'd2, 5'd0,  6'h23, 1'b0, mk(4'hF,2'd0,1'b0,4'h3,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("and",       1, 6'h00, 5'd1, 5'd2, 5'd0,  6'h24, 1'b0, mk(4'hF,2'd0,1'b0,4'h4,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("xor",       1, 6'h00, 5'd1, 5'd2, 5'd0,  6'h26, 1'b0, mk(4'hF,2'd0,1'b0,4'h6,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("nor",       1, 6'h00, 5'd1, 5'd2, 5'd0,  6'h27, 1'b0, mk(4'hF,2'd0,1'b0,4'h7,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("slt",       1, 6'h00, 5'd1, 5'd2, 5'd0,  6'h2A, 1'b1, mk(4'hF,2'd0,1'b0,4'h8,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("sltu",      1, 6'h00, 5'd1, 5'd2, 5'd0,  6'h2B, 1'b0, mk(4'hF,2'd0,1'b0,4'h9,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("bltz",      1, 6'h01, 5'd7, 5'd0, 5'd0,  6'h00, 1'b0, mk(4'h0,2'd3,1'b0,4'h2,1'b0,1'b0,1'b0,3'd3,2'd0,1'b0,1'b1));
    step("bgez",      1, 6'h01, 5'd7, 5'd1, 5'd0,  6'h00, 1'b0, mk(4'h0,2'd3,1'b0,4'h2,1'b0,1'b0,1'b0,3'd4,2'd0,1'b0,1'b1));
    step("regimm_x",  1, 6'h01, 5'd7, 5'd2, 5'd0,  6'h00, 1'b0, mk(4'h0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("beq",       1, 6'h04, 5'd7, 5'd5, 5'd0,  6'h00, 1'b0, mk(4'h0,2'd0,1'b0,4'h2,1'b0,1'b0,1'b0,3'd1,2'd0,1'b0,1'b0));
    step("bne",       1, 6'h05, 5'd7, 5'd5, 5'd0,  6'h00, 1'b0, mk(4'h0,2'd0,1'b0,4'h2,1'b0,1'b0,1'b0,3'd2,2'd0,1'b0,1'b0));
    step("blez",      1, 6'h06, 5'd7, 5'd0, 5'd0,  6'h00, 1'b0, mk(4'h0,2'd3,1'b0,4'h2,1'b0,1'b0,1'b0,3'd5,2'd0,1'b0,1'b1));
    step("bgtz",      1, 6'h07, 5'd7, 5'd0, 5'd0,  6'h00, 1'b0, mk(4'h0,2'd3,1'b0,4'h2,1'b0,1'b0,1'b0,3'd6,2'd0,1'b0,1'b1));
    step("addi",      1, 6'h08, 5'd2, 5'd3, 5'd0,  6'h00, 1'b0, mk(4'hF,2'd1,1'b1,4'h0,1'b1,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("addi_ovf",  1, 6'h08, 5'd2, 5'd3, 5'd0,  6'h00, 1'b1, mk(4'h0,2'd1,1'b1,4'h0,1'b1,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("addiu_ovf", 1, 6'h09, 5'd2, 5'd3, 5'd0,  6'h00, 1'b1, mk(4'hF,2'd1,1'b1,4'h1,1'b1,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("slti",      1, 6'h0A, 5'd2, 5'd3, 5'd0,  6'h00, 1'b0, mk(4'hF,2'd1,1'b1,4'h8,1'b1,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("sltiu",     1, 6'h0B, 5'd2, 5'd3, 5'd0,  6'h00, 1'b0, mk(4'hF,2'd1,1'b1,4'h9,1'b1,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("ori",       1, 6'h0D, 5'd2, 5'd3, 5'd0,  6'h00, 1'b0, mk(4'hF,2'd1,1'b0,4'h5,1'b1,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("xori",      1, 6'h0E, 5'd2, 5'd3, 5'd0,  6'h00, 1'b0, mk(4'hF,2'd1,1'b0,4'h6,1'b1,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("lui",       1, 6'h0F, 5'd0, 5'd3, 5'd0,  6'h00, 1'b0, mk(4'hF,2'd2,1'b0,4'hF,1'b1,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("sll",       1, 6'h00, 5'd0, 5'd3, 5'd3,  6'h00, 1'b0, mk(4'hF,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1,3'd0,2'd0,1'b0,1'b0));
    step("srl",       1, 6'h00, 5'd0, 5'd3, 5'd4,  6'h02, 1'b0, mk(4'hF,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1,3'd0,2'd1,1'b0,1'b0));
    step("rotr",      1, 6'h00, 5'd1, 5'd3, 5'd4,  6'h02, 1'b0, mk(4'hF,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1,3'd0,2'd3,1'b0,1'b0));
    step("srl_x",     1, 6'h00, 5'd2, 5'd3, 5'd4,  6'h02, 1'b0, mk(4'h0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("sra",       1, 6'h00, 5'd0, 5'd3, 5'd4,  6'h03, 1'b0, mk(4'hF,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1,3'd0,2'd2,1'b0,1'b0));
    step("sllv",      1, 6'h00, 5'd6, 5'd3, 5'd0,  6'h04, 1'b0, mk(4'hF,2'd0,1'b0,4'h0,1'b0,1'b1,1'b1,3'd0,2'd0,1'b0,1'b0));
    step("srlv",      1, 6'h00, 5'd6, 5'd3, 5'd0,  6'h06, 1'b0, mk(4'hF,2'd0,1'b0,4'h0,1'b0,1'b1,1'b1,3'd0,2'd1,1'b0,1'b0));
    step("rotrv",     1, 6'h00, 5'd6, 5'd3, 5'd1,  6'h06, 1'b0, mk(4'hF,2'd0,1'b0,4'h0,1'b0,1'b1,1'b1,3'd0,2'd3,1'b0,1'b0));
    step("srav",      1, 6'h00, 5'd6, 5'd3, 5'd0,  6'h07, 1'b0, mk(4'hF,2'd0,1'b0,4'h0,1'b0,1'b1,1'b1,3'd0,2'd2,1'b0,1'b0));
    step("seb",       1, 6'h1F, 5'd0, 5'd3, 5'h10, 6'h20, 1'b0, mk(4'hF,2'd0,1'b0,4'hC,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("seh",       1, 6'h1F, 5'd0, 5'd3, 5'h18, 6'h20, 1'b0, mk(4'hF,2'd0,1'b0,4'hD,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("bshfl_x",   1, 6'h1F, 5'd0, 5'd3, 5'h05, 6'h20, 1'b0, mk(4'h0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("clz",       1, 6'h1C, 5'd4, 5'd0, 5'd0,  6'h20, 1'b0, mk(4'hF,2'd0,1'b0,4'hA,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("clo",       1, 6'h1C, 5'd4, 5'd0, 5'd0,  6'h21, 1'b0, mk(4'hF,2'd0,1'b0,4'hB,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("j",         1, 6'h02, 5'd9, 5'd9, 5'd9,  6'h3F, 1'b0, mk(4'h0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b0,3'd0,2'd0,1'b1,1'b0));
    step("illegal",   1, 6'h3F, 5'd0, 5'd0, 5'd0,  6'h20, 1'b0, mk(4'h0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("rst_j",     0, 6'h02, 5'd0, 5'd0, 5'd0,  6'h00, 1'b0, mk(4'h0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("rst_ori",   0, 6'h0D, 5'd0, 5'd0, 5'd0,  6'h00, 1'b0, mk(4'h0,2'd1,1'b0,4'h5,1'b1,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("rst_bne",   0, 6'h05, 5'd0, 5'd0, 5'd0,  6'h00, 1'b0, mk(4'h0,2'd0,1'b0,4'h2,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));
    step("post_rst",  1, 6'h00, 5'd1, 5'd2, 5'd0,  6'h21, 1'b0, mk(4'hF,2'd0,1'b0,4'h1,1'b0,1'b0,1'b0,3'd0,2'd0,1'b0,1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
